// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arms on a command pulse, waits for the synchronised
// trigger, then streams packed sample words into the FIFO until count or full.
module adc_capture_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [9:0]       adc_data_i,
    input  logic             adc_or_i,
    input  logic             locked_i,
    input  logic             trigger_i,
    input  logic             trigger_mode_i,
    input  logic             trigger_wait_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] num_samples_i,
    input  logic             fifo_full_i,
    output logic [15:0]      fifo_din_o,
    output logic             fifo_wr_en_o,
    output logic             armed_o,
    output logic             capturing_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sample_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INACTIVE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic             trig_m, trig_s;
    logic             active;
    logic [CNT_W-1:0] limit, limit_nxt;
    logic [CNT_W-1:0] cnt_nxt, cnt_inc;
    logic [15:0]      din_nxt;
    logic             wr_nxt;
    logic [15:0]      word;

    assign active = (trig_s == trigger_mode_i);
    assign word   = {1'b1, 2'b00, locked_i, adc_or_i, adc_data_i[9:7], 1'b0, adc_data_i[6:0]};
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (&sample_count_o) ? sample_count_o : sample_count_o + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state          <= IDLE;
            trig_m         <= 1'b0;
            trig_s         <= 1'b0;
            limit          <= '0;
            fifo_din_o     <= '0;
            fifo_wr_en_o   <= 1'b0;
            sample_count_o <= '0;
        end else begin
            state          <= state_nxt;
            trig_m         <= trigger_i;
            trig_s         <= trig_m;
            limit          <= limit_nxt;
            fifo_din_o     <= din_nxt;
            fifo_wr_en_o   <= wr_nxt;
            sample_count_o <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        limit_nxt = limit;
        din_nxt   = fifo_din_o;
        wr_nxt    = 1'b0;
        cnt_nxt   = sample_count_o;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm_i) begin
                        cnt_nxt   = '0;
                        state_nxt = (trigger_wait_i && active) ? WAIT_INACTIVE : ARMED;
                    end
                end
                WAIT_INACTIVE: if (!active) state_nxt = ARMED;
                ARMED: begin
                    // Request is frozen here so later changes cannot shorten the burst.
                    if (active) begin
                        state_nxt = CAPTURE;
                        limit_nxt = num_samples_i;
                    end
                end
                CAPTURE: begin
                    if (fifo_full_i) begin
                        state_nxt = DONE;
                    end else begin
                        wr_nxt  = 1'b1;
                        din_nxt = word;
                        cnt_nxt = cnt_inc;
                        if (limit != '0 && cnt_inc == limit) state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign armed_o     = (state == WAIT_INACTIVE) || (state == ARMED);
    assign capturing_o = (state == CAPTURE);
    assign done_o      = (state == DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_adc_capture_ctrl;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, trig, mode, twait, arm, abort, full, a_or, lock;
    logic [9:0]    adc;
    logic [CW-1:0] num;
    logic [15:0]   din;
    logic          wr_en, armed, capturing, done;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    adc_capture_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(rst_n), .adc_data_i(adc), .adc_or_i(a_or),
        .locked_i(lock), .trigger_i(trig), .trigger_mode_i(mode),
        .trigger_wait_i(twait), .arm_i(arm), .abort_i(abort),
        .num_samples_i(num), .fifo_full_i(full), .fifo_din_o(din),
        .fifo_wr_en_o(wr_en), .armed_o(armed), .capturing_o(capturing),
        .done_o(done), .sample_count_o(count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Behavioural model. Phase: 0 idle, 1 waiting for inactive, 2 armed, 3 capturing, 4 done.
    int          ph = 0, mcnt = 0, lim = 0;
    bit          mwr = 0;
    logic [15:0] mdin = 0;
    bit          hist[2] = '{0, 0};

    function automatic logic [15:0] pack(logic [9:0] d, logic o, logic l);
        return 16'h8000 | (16'(l) << 12) | (16'(o) << 11) | (16'(d >> 7) << 8) | 16'(d & 10'h7F);
    endfunction

    always @(posedge clk) begin
        bit act;
        if (!rst_n) begin
            ph = 0; mcnt = 0; mwr = 0; mdin = 0; hist = '{0, 0};
        end else begin
            act = (hist[1] == mode);
            mwr = 0;
            if (abort) ph = 0;
            else if ((ph == 0 || ph == 4) && arm) begin
                mcnt = 0;
                ph   = (twait && act) ? 1 : 2;
            end else if (ph == 1 && !act) ph = 2;
            else if (ph == 2 && act) begin
                ph  = 3;
                lim = int'(num);
            end else if (ph == 3) begin
                if (full) ph = 4;
                else begin
                    mwr  = 1;
                    mdin = pack(adc, a_or, lock);
                    if (mcnt < MAX) mcnt++;
                    if (lim != 0 && mcnt == lim) ph = 4;
                end
            end
            hist[1] = hist[0];
            hist[0] = trig;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en", wr_en, mwr);
            chk("armed", armed, (ph == 1 || ph == 2));
            chk("capturing", capturing, ph == 3);
            chk("done", done, ph == 4);
            chk("count", count, mcnt);
            if (mwr) chk("din", din, mdin);
        end
    end

    task automatic pulse_arm();
        arm = 1; @(negedge clk); arm = 0;
    endtask

    task automatic run(input int n, output int writes);
        writes = 0;
        repeat (n) begin
            @(negedge clk);
            if (wr_en) writes++;
        end
    endtask

    initial begin
        int w, held;
        bit first;
        rst_n = 0; trig = 0; mode = 1; twait = 0; arm = 0; abort = 0;
        full = 0; a_or = 0; lock = 0; adc = 0; num = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_din", din, 0); chk("rst_wr", wr_en, 0); chk("rst_armed", armed, 0);
        chk("rst_cap", capturing, 0); chk("rst_done", done, 0); chk("rst_cnt", count, 0);
        rst_n = 1;
        @(negedge clk);

        // Basic capture of 8 words, first word packs 0x3FF.
        num = 8; adc = 10'h3FF;
        pulse_arm();
        chk("arm_latency", armed, 1);
        trig = 1;
        w = 0; first = 1;
        repeat (20) begin
            @(negedge clk);
            if (wr_en) begin
                if (first) chk("pack_3ff", din, 16'h877F);
                first = 0; w++;
                adc = 10'(w * 37);
            end
        end
        chk("basic_writes", w, 8); chk("basic_done", done, 1); chk("basic_cnt", count, 8);

        // Wait-for-inactive with trigger held high.
        twait = 1;
        pulse_arm();
        chk("wait_armed", armed, 1);
        run(6, w);
        chk("wait_nowrite", w, 0); chk("wait_still_armed", armed, 1);
        trig = 0;
        run(4, w);
        trig = 1;
        @(negedge clk);
        @(negedge clk); chk("lat_e1_cap", capturing, 0);
        @(negedge clk); chk("lat_e2_cap", capturing, 1); chk("lat_e2_wr", wr_en, 0);
        @(negedge clk); chk("lat_e3_wr", wr_en, 1);
        run(20, w);
        chk("wait_done", done, 1);

        // Immediate trigger, high then low polarity.
        twait = 0;
        pulse_arm();
        @(negedge clk); chk("imm_hi_cap", capturing, 1);
        run(20, w);
        mode = 0; trig = 0;
        run(3, w);
        pulse_arm();
        @(negedge clk); chk("imm_lo_cap", capturing, 1);
        run(20, w);
        chk("imm_lo_done", done, 1);

        // Fill until FIFO full after 5 writes.
        mode = 1; trig = 1; num = 0;
        run(3, w);
        pulse_arm();
        w = 0;
        repeat (30) begin
            @(negedge clk);
            if (wr_en) w++;
            if (wr_en && count == 5) full = 1;
        end
        chk("full_writes", w, 5); chk("full_done", done, 1); chk("full_cnt", count, 5);
        full = 0;

        // Arm ignored mid-capture, then abort.
        pulse_arm();
        run(4, w);
        held = int'(count);
        pulse_arm();
        chk("arm_in_cap", capturing, 1); chk("arm_in_cap_cnt", count, held + 1);
        run(2, w);
        held = int'(count);
        abort = 1; @(negedge clk); abort = 0;
        chk("abort_wr", wr_en, 0); chk("abort_cap", capturing, 0);
        chk("abort_armed", armed, 0); chk("abort_cnt", count, held);

        // Reset mid-capture.
        pulse_arm();
        run(4, w);
        rst_n = 0; @(negedge clk); rst_n = 1;
        chk("mrst_wr", wr_en, 0); chk("mrst_cap", capturing, 0); chk("mrst_cnt", count, 0);
        chk("mrst_din", din, 0);

        // Counter saturation, then re-arm from DONE.
        pulse_arm();
        run(25, w);
        chk("sat_cnt", count, MAX); chk("sat_cap", capturing, 1);
        num = 3; full = 1; @(negedge clk); full = 0;
        chk("sat_done", done, 1);
        pulse_arm();
        chk("rearm_done", done, 0); chk("rearm_cnt", count, 0); chk("rearm_armed", armed, 1);
        run(8, w);
        chk("rearm_writes", w, 3);

        // Randomized traffic.
        repeat (4000) begin
            @(negedge clk);
            adc   = 10'($urandom);
            a_or  = 1'($urandom);
            lock  = 1'($urandom);
            if ($urandom_range(7) == 0) trig = ~trig;
            arm   = ($urandom_range(9) == 0);
            abort = ($urandom_range(59) == 0);
            full  = ($urandom_range(11) == 0);
            if (arm) num = CW'($urandom_range(6));
            if ($urandom_range(99) == 0) mode = ~mode;
            if ($urandom_range(99) == 0) twait = ~twait;
            rst_n = ($urandom_range(299) != 0);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
